ff_input_conditioner: RTL

FF_INPUT_CONDITIONER -- requirements
Module: ff_input_conditioner

---
 rtl/ff_input_conditioner.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ff_input_conditioner.sv
// Per-channel input conditioner: optional inversion, 2-flop synchroniser, counter debounce,
// press/release pulses and optional auto-repeat. The release pulse port is named
// release_pulse because "release" is a reserved word.
module ff_input_conditioner #(
  parameter int unsigned      NCH             = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter int unsigned      CNT_W           = 20,
  parameter logic [NCH-1:0]   INVERT          = '0,
  parameter bit               REPEAT_EN       = 1'b0,
  parameter int unsigned      REPEAT_DELAY    = 8,
  parameter int unsigned      REPEAT_PERIOD   = 4
) (
  input  logic           sysclk,
  input  logic           reset,
  input  logic [NCH-1:0] raw_in,
  output logic [NCH-1:0] level,
  output logic [NCH-1:0] press,
  output logic [NCH-1:0] release_pulse,
  output logic           any_level
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRepeat
  } rep_state_e;

  logic [NCH-1:0] s1_q, s2_q;
  logic [NCH-1:0] rise, fall, rep_fire;
  logic           any_q;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw_in ^ INVERT;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_deb
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             press_q, rel_q;
    logic             rise_c, fall_c;

    // Any sample that agrees with the current level restarts qualification.
    always_comb begin
      cnt_d  = '0;
      lvl_d  = lvl_q;
      rise_c = 1'b0;
      fall_c = 1'b0;
      if (s2_q[i] != lvl_q) begin
        if (cnt_q == CntMax) begin
          lvl_d  = s2_q[i];
          rise_c = s2_q[i];
          fall_c = ~s2_q[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        press_q <= rise_c | rep_fire[i];
        rel_q   <= fall_c;
      end
    end

    assign rise[i]          = rise_c;
    assign fall[i]          = fall_c;
    assign level[i]         = lvl_q;
    assign press[i]         = press_q;
    assign release_pulse[i] = rel_q;
  end

  if (REPEAT_EN) begin : g_rep
    localparam logic [7:0] RepDelayM1  = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] RepPeriodM1 = 8'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] pre_q;
    logic             tick;

    assign tick = (pre_q == CntMax);

    always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
        pre_q <= '0;
      end else if (tick) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
      rep_state_e st_q, st_d;
      logic [7:0] rcnt_q, rcnt_d;
      logic       fire;

      // A fall wins over a coincident repeat event, so press never pairs with release.
      always_comb begin
        st_d   = st_q;
        rcnt_d = rcnt_q;
        fire   = 1'b0;
        if (fall[i]) begin
          st_d   = StIdle;
          rcnt_d = '0;
        end else begin
          unique case (st_q)
            StIdle: begin
              if (rise[i]) begin
                st_d   = StWait;
                rcnt_d = '0;
              end
            end
            StWait: begin
              if (tick) begin
                if (rcnt_q == RepDelayM1) begin
                  fire   = 1'b1;
                  rcnt_d = '0;
                  st_d   = StRepeat;
                end else if (rcnt_q != 8'hff) begin
                  rcnt_d = rcnt_q + 8'd1;
                end
              end
            end
            StRepeat: begin
              if (tick) begin
                if (rcnt_q == RepPeriodM1) begin
                  fire   = 1'b1;
                  rcnt_d = '0;
                end else if (rcnt_q != 8'hff) begin
                  rcnt_d = rcnt_q + 8'd1;
                end
              end
            end
            default: begin
              st_d   = StIdle;
              rcnt_d = '0;
            end
          endcase
        end
      end

      always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
          st_q   <= StIdle;
          rcnt_q <= '0;
        end else begin
          st_q   <= st_d;
          rcnt_q <= rcnt_d;
        end
      end

      assign rep_fire[i] = fire;
    end
  end else begin : g_no_rep
    assign rep_fire = '0;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |level;
    end
  end

  assign any_level = any_q;

endmodule
